// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: walks round keys 10 -> 0, one per cycle, over valid/ready.
// Optional AES_INV_KS_FWD_PRELOAD_EN: key_in is the cipher key, expanded forward internally first.
module aes_inv_key_schedule #(
   parameter int KEY_LENGTH  = 128,
   parameter int WORD_LENGTH = 32,
   parameter int NUM_ROUNDS  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [KEY_LENGTH-1:0] key_in,
   output logic                  in_ready,
   output logic [KEY_LENGTH-1:0] key_out,
   output logic [3:0]            key_round,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  done
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[(255 - int'(b)) * 8 +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_FWD  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [KEY_LENGTH-1:0]   key_q, key_d;
   logic [3:0]              round_q, round_d;
   logic                    done_q, done_d;

   logic [WORD_LENGTH-1:0]  k0, k1, k2, k3;
   logic [WORD_LENGTH-1:0]  p1, p2, p3, t0;
   logic [WORD_LENGTH-1:0]  sb_in, sb_out;
   logic [3:0]              rc_idx;
   logic [KEY_LENGTH-1:0]   prev_key;

   assign {k0, k1, k2, k3} = key_q;
   assign p3 = k3 ^ k2;
   assign p2 = k2 ^ k1;
   assign p1 = k1 ^ k0;

   // One S-box bank is shared: the forward step substitutes k3, the inverse step p3 (= w[4r-1]).
`ifdef AES_INV_KS_FWD_PRELOAD_EN
   logic [WORD_LENGTH-1:0]  f1, f2, f3;
   logic [KEY_LENGTH-1:0]   fwd_key;
   assign sb_in  = (state_q == S_FWD) ? {k3[WORD_LENGTH-9:0], k3[WORD_LENGTH-1 -: 8]}
                                      : {p3[WORD_LENGTH-9:0], p3[WORD_LENGTH-1 -: 8]};
   assign rc_idx = (state_q == S_FWD) ? round_q + 4'd1 : round_q;
   assign f1      = k1 ^ t0;
   assign f2      = k2 ^ f1;
   assign f3      = k3 ^ f2;
   assign fwd_key = {t0, f1, f2, f3};
`else
   assign sb_in  = {p3[WORD_LENGTH-9:0], p3[WORD_LENGTH-1 -: 8]};
   assign rc_idx = round_q;
`endif

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      assign sb_out[8*g +: 8] = sbox(sb_in[8*g +: 8]);
   end

   assign t0       = k0 ^ sb_out ^ {rcon(rc_idx), {(WORD_LENGTH-8){1'b0}}};
   assign prev_key = {t0, p1, p2, p3};

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               key_d = key_in;
`ifdef AES_INV_KS_FWD_PRELOAD_EN
               round_d = 4'd0;
               state_d = S_FWD;
`else
               round_d = LAST_ROUND;
               state_d = S_EMIT;
`endif
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (round_q == 4'd0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  key_d   = prev_key;
                  round_d = round_q - 4'd1;
               end
            end
         end
`ifdef AES_INV_KS_FWD_PRELOAD_EN
         S_FWD: begin
            key_d   = fwd_key;
            round_d = round_q + 4'd1;
            if (round_q == LAST_ROUND - 4'd1) state_d = S_EMIT;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         key_q   <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_EMIT);
   assign key_out   = key_q;
   assign key_round = round_q;
   assign done      = done_q;

endmodule
